// File: rtl/aes_round_ctrl.sv
// Sequencer for the 32-bit-radix AES round datapath: initial key add, 4 word cycles + 1 commit per round.
// Latency: out_valid 1+5*N cycles after accept with keys always ready; each key stall adds one cycle.
// Backpressure: key_valid stalls ARK0/COMMIT only; out_ready holds DONE; in_ready low whenever busy.
module aes_round_ctrl #(
    parameter int ROUNDS_128 = 10,
    parameter int ROUNDS_192 = 12,
    parameter int ROUNDS_256 = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] mode_in,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       key_valid,
    output logic       key_req,
    output logic [3:0] key_round,
    output logic [3:0] round,
    output logic [2:0] width_sel,
    output logic [1:0] mode,
    output logic       accum_en,
    output logic       state_load,
    output logic       state_we,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARK0   = 3'd1,
        S_WORD   = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] round_q;
    logic [1:0] word_cnt;
    logic [1:0] mode_q;
    logic       load_q;
    logic [3:0] last_round;

    // Final round index for the latched key size; mode 11 falls back to AES-256.
    always_comb begin
        last_round = 4'(ROUNDS_256);
        case (mode_q)
            2'b00:   last_round = 4'(ROUNDS_128);
            2'b01:   last_round = 4'(ROUNDS_192);
            default: last_round = 4'(ROUNDS_256);
        endcase
    end

    // Main sequencer: state, round index, word counter, latched mode and the plaintext-load strobe.
    // state_load is registered so in_valid never reaches an output combinationally; it is high
    // for the single cycle following the accepting edge. Round 0 reads data_in directly, so the
    // ARK0 write does not depend on the load having landed first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            round_q  <= 4'd0;
            word_cnt <= 2'd0;
            mode_q   <= 2'b00;
            load_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mode_q   <= mode_in;
                        load_q   <= 1'b1;
                        round_q  <= 4'd0;
                        word_cnt <= 2'd0;
                        state    <= S_ARK0;
                    end
                end
                S_ARK0: begin
                    if (key_valid) begin
                        round_q  <= 4'd1;
                        word_cnt <= 2'd0;
                        state    <= S_WORD;
                    end
                end
                S_WORD: begin
                    // Four back-to-back word cycles; the counter wraps to 0 as COMMIT is entered.
                    word_cnt <= word_cnt + 2'd1;
                    if (word_cnt == 2'd3) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (key_valid) begin
                        if (round_q == last_round) begin
                            state <= S_DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            state   <= S_WORD;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        round_q <= 4'd0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state register; only state_we also looks at key_valid.
    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign accum_en   = (state == S_WORD);
    assign key_req    = (state == S_ARK0) || (state == S_COMMIT);
    assign key_round  = round_q;
    assign round      = round_q;
    assign width_sel  = {1'b0, word_cnt};
    assign mode       = mode_q;
    assign state_load = load_q;
    assign state_we   = key_valid && ((state == S_ARK0) || (state == S_COMMIT));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: all key sizes, key stalls, result backpressure, async reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Summary line reports vectors applied and miscompares.
module tb_aes_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode_in;
    logic       out_valid;
    logic       out_ready;
    logic       key_valid;
    logic       key_req;
    logic [3:0] key_round;
    logic [3:0] round;
    logic [2:0] width_sel;
    logic [1:0] mode;
    logic       accum_en;
    logic       state_load;
    logic       state_we;
    logic       busy;

    int vectors;
    int miscompares;

    aes_round_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode_in    (mode_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_valid  (key_valid),
        .key_req    (key_req),
        .key_round  (key_round),
        .round      (round),
        .width_sel  (width_sel),
        .mode       (mode),
        .accum_en   (accum_en),
        .state_load (state_load),
        .state_we   (state_we),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present a start with the given mode and take the accepting edge.
    task automatic start(input logic [1:0] m);
        mode_in   = m;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        key_valid = 1'b1;
        check("accept_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Walk one block from the cycle after the accepting edge up to DONE against a small
    // phase model (0=ARK0, 1=WORD, 2=COMMIT, 3=DONE). key_valid is dropped for stall_len
    // cycles in the COMMIT of stall_round. Returns edges counted from the accepting edge.
    task automatic run_block(input int nr, input int stall_round, input int stall_len,
                             input bit toggle_mode, output int edges, output int we_cnt,
                             output int acc_cnt, output int seq_err);
        int  ph;
        int  mr;
        int  mw;
        int  left;
        bit  kv;
        ph = 0; mr = 0; mw = 0; left = stall_len;
        edges = 0; we_cnt = 0; acc_cnt = 0; seq_err = 0;
        for (int c = 0; c < 400; c++) begin
            if (round !== 4'(mr)) seq_err++;
            if (width_sel !== {1'b0, 2'(mw)}) seq_err++;
            if (accum_en !== (ph == 1)) seq_err++;
            if (key_req !== (ph == 0 || ph == 2)) seq_err++;
            if ((ph == 0 || ph == 2) && key_round !== 4'(mr)) seq_err++;
            if (out_valid !== (ph == 3)) seq_err++;
            if (busy !== 1'b1) seq_err++;
            if (in_ready !== 1'b0) seq_err++;
            if (state_load !== (c == 0)) seq_err++;
            if (ph == 3) break;
            kv = !(ph == 2 && mr == stall_round && left > 0);
            if (!kv) left--;
            key_valid = kv;
            if (toggle_mode) mode_in = mode_in + 2'd1;
            #1;
            if (state_we !== ((ph == 0 || ph == 2) && kv)) seq_err++;
            we_cnt  += int'(state_we);
            acc_cnt += int'(accum_en);
            case (ph)
                0: if (kv) begin ph = 1; mr = 1; mw = 0; end
                1: if (mw == 3) begin mw = 0; ph = 2; end else mw++;
                2: if (kv) begin
                       if (mr == nr) ph = 3;
                       else begin mr++; ph = 1; end
                   end
                default: ;
            endcase
            tick();
            edges++;
        end
        key_valid = 1'b1;
    endtask

    // Accept the result and confirm return to IDLE.
    task automatic finish_block(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check(tag, 32'(in_ready), 1);
    endtask

    initial begin
        int edges;
        int we_cnt;
        int acc_cnt;
        int seq_err;
        int err;
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode_in   = 2'b00;
        out_ready = 1'b0;
        key_valid = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_in_ready",   32'(in_ready),   1);
        check("rst_busy",       32'(busy),       0);
        check("rst_out_valid",  32'(out_valid),  0);
        check("rst_round",      32'(round),      0);
        check("rst_width_sel",  32'(width_sel),  0);
        check("rst_mode",       32'(mode),       0);
        check("rst_accum_en",   32'(accum_en),   0);
        check("rst_state_load", 32'(state_load), 0);
        check("rst_state_we",   32'(state_we),   0);
        check("rst_key_req",    32'(key_req),    0);
        #3 rst_n = 1'b1;
        tick();
        check("idle_state_load", 32'(state_load), 0);

        // AES-128, keys always ready
        start(2'b00);
        run_block(10, -1, 0, 1'b0, edges, we_cnt, acc_cnt, seq_err);
        check("a128_seq",      32'(seq_err), 0);
        check("a128_edges",    32'(edges),   51);
        check("a128_state_we", 32'(we_cnt),  11);
        check("a128_accum",    32'(acc_cnt), 40);
        check("a128_mode",     32'(mode),    0);
        check("a128_last_rnd", 32'(round),   10);
        finish_block("a128_idle");
        check("a128_idle_busy", 32'(busy), 0);

        // AES-256 via mode 10
        start(2'b10);
        run_block(14, -1, 0, 1'b0, edges, we_cnt, acc_cnt, seq_err);
        check("a256_seq",      32'(seq_err), 0);
        check("a256_edges",    32'(edges),   71);
        check("a256_state_we", 32'(we_cnt),  15);
        check("a256_accum",    32'(acc_cnt), 56);
        check("a256_mode",     32'(mode),    2);
        check("a256_last_rnd", 32'(round),   14);
        finish_block("a256_idle");

        // Mode 11 defaults to 256
        start(2'b11);
        run_block(14, -1, 0, 1'b0, edges, we_cnt, acc_cnt, seq_err);
        check("m11_seq",      32'(seq_err), 0);
        check("m11_edges",    32'(edges),   71);
        check("m11_mode",     32'(mode),    3);
        check("m11_last_rnd", 32'(round),   14);
        finish_block("m11_idle");

        // AES-192 with a 3-cycle key stall in the COMMIT of round 5
        start(2'b01);
        run_block(12, 5, 3, 1'b0, edges, we_cnt, acc_cnt, seq_err);
        check("a192_stall_seq", 32'(seq_err), 0);
        check("a192_edges",     32'(edges),   64);
        check("a192_state_we",  32'(we_cnt),  13);
        check("a192_accum",     32'(acc_cnt), 48);
        check("a192_mode",      32'(mode),    1);

        // Hold DONE for 10 cycles with a pending start
        in_valid = 1'b1;
        mode_in  = 2'b00;
        err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) err++;
        end
        check("done_hold", 32'(err), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("done_to_idle_ready", 32'(in_ready),  1);
        check("done_to_idle_valid", 32'(out_valid), 0);
        // in_valid still high: accepted on the next edge, then held high with mode_in toggling
        tick();
        check("restart_busy", 32'(busy), 1);
        run_block(10, -1, 0, 1'b1, edges, we_cnt, acc_cnt, seq_err);
        check("toggle_seq",   32'(seq_err), 0);
        check("toggle_edges", 32'(edges),   51);
        check("toggle_mode",  32'(mode),    0);
        finish_block("toggle_idle");

        // Async reset in round 7 of AES-256
        start(2'b10);
        for (int i = 0; i < 32; i++) tick();
        check("pre_rst_round", 32'(round),     7);
        check("pre_rst_wsel",  32'(width_sel), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",     32'(busy),      0);
        check("arst_in_ready", 32'(in_ready),  1);
        check("arst_round",    32'(round),     0);
        check("arst_key_req",  32'(key_req),   0);
        check("arst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        key_valid = 1'b1;
        err = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) err++;
        end
        check("post_rst_quiet", 32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
